// File: rtl/mem_bus_arbiter_if.sv
// Request/ready burst bus between N masters, the arbiter and one slave port.
// The master modport is the arbiter's view; slave is the complementary view.
interface mem_bus_arbiter_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 22
);
  logic [N_MASTERS-1:0]        m_request;
  logic [N_MASTERS-1:0]        m_write_enable;
  logic [N_MASTERS-1:0]        m_last4;
  logic [N_MASTERS*ADDR_W-1:0] m_address;
  logic [N_MASTERS*DATA_W-1:0] m_data_write;
  logic [N_MASTERS-1:0]        m_ready;
  logic [DATA_W-1:0]           m_data_read;
  logic                        s_request;
  logic                        s_write_enable;
  logic                        s_last4;
  logic [ADDR_W-1:0]           s_address;
  logic [DATA_W-1:0]           s_data_write;
  logic                        s_ready;
  logic [DATA_W-1:0]           s_data_read;
  logic [N_MASTERS-1:0]        grant;

  modport master (
    input  m_request, m_write_enable, m_last4, m_address, m_data_write, s_ready, s_data_read,
    output m_ready, m_data_read, s_request, s_write_enable, s_last4, s_address, s_data_write,
           grant
  );

  modport slave (
    output m_request, m_write_enable, m_last4, m_address, m_data_write, s_ready, s_data_read,
    input  m_ready, m_data_read, s_request, s_write_enable, s_last4, s_address, s_data_write,
           grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// N-master burst arbiter onto a single slave port: round-robin or fixed priority,
// optional burst cap with automatic last4, one-cycle release gap between grants.
module mem_bus_arbiter #(
  parameter int unsigned N_MASTERS   = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned MAX_BURST   = 64,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  mem_bus_arbiter_if.master bus
);
  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 seen_ready_q, seen_ready_d;

  logic [N_MASTERS-1:0] req;
  logic                 cur_req, beat, last_beat, cap_last4;
  logic [IDX_W-1:0]     ptr_inc;

  function automatic logic [IDX_W-1:0] pick(input logic [N_MASTERS-1:0] r,
                                            input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(N_MASTERS); k++) begin
      int j;
      j = ROUND_ROBIN ? (int'(ptr) + k) % int'(N_MASTERS) : k;
      if (!found && r[IDX_W'(j)]) begin
        win   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [N_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign req       = bus.m_request;
  assign cur_req   = req[gidx_q];
  // A master dropping its request in the same cycle as s_ready is not a beat.
  assign beat      = (state_q == StGrant) && cur_req && bus.s_ready;
  assign ptr_inc   = (gidx_q == IDX_W'(N_MASTERS - 1)) ? '0 : gidx_q + IDX_W'(1);
  assign cap_last4 = (MAX_BURST != 0) && ((32'(beat_cnt_q) + 32'd4) >= MAX_BURST);
  assign last_beat = (MAX_BURST != 0) && beat && (32'(beat_cnt_q) == MAX_BURST - 1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    seen_ready_d = seen_ready_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d      = StGrant;
          gidx_d       = pick(req, rr_ptr_q);
          grant_d      = onehot(gidx_d);
          beat_cnt_d   = '0;
          seen_ready_d = 1'b0;
        end
      end
      StGrant: begin
        if (beat) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (bus.s_ready) seen_ready_d = 1'b1;
        if (!cur_req || (seen_ready_q && !bus.s_ready) || last_beat) state_d = StRelease;
      end
      StRelease: begin
        // Grant and data mux stay on the old winner so the trailing write beat lands.
        rr_ptr_d     = ptr_inc;
        beat_cnt_d   = '0;
        seen_ready_d = 1'b0;
        if (|req) begin
          state_d = StGrant;
          gidx_d  = pick(req, ptr_inc);
          grant_d = onehot(gidx_d);
        end else begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.m_data_read    = bus.s_data_read;
    bus.m_ready        = '0;
    bus.s_request      = 1'b0;
    bus.s_last4        = 1'b0;
    bus.s_write_enable = 1'b0;
    bus.s_address      = '0;
    bus.s_data_write   = '0;
    bus.grant          = grant_q;
    if (state_q != StIdle) begin
      bus.s_write_enable = bus.m_write_enable[gidx_q];
      bus.s_address      = bus.m_address[int'(gidx_q)*ADDR_W +: ADDR_W];
      bus.s_data_write   = bus.m_data_write[int'(gidx_q)*DATA_W +: DATA_W];
    end
    if (state_q == StGrant) begin
      bus.s_request       = cur_req;
      bus.s_last4         = bus.m_last4[gidx_q] | cap_last4;
      bus.m_ready[gidx_q] = bus.s_ready;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      beat_cnt_q   <= '0;
      seen_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      seen_ready_q <= seen_ready_d;
    end
  end
endmodule
